// File: rtl/jb_iq_gain_sched.sv
// Per-user IQ gain scheduler: shadow/active gain banks swapped at frame boundaries.
// Optional macro JB_GAIN_SCHED_RAMP_EN ramps the fraction gain toward the new value per beat.
module jb_iq_gain_sched #(
    parameter int                   PRECISION  = 16,
    parameter int                   SCALER_BW  = 4,
    parameter int                   USR_ID_BW  = 2,
    parameter int                   IDLE_TO    = 64,
    parameter logic [PRECISION-1:0] RESET_FRAC = 'h7FFF,
    parameter logic [PRECISION-1:0] RAMP_STEP  = 'h0100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 cfg_wr_en,
    input  logic [USR_ID_BW-1:0] cfg_wr_usr,
    input  logic                 cfg_wr_sign,
    input  logic [SCALER_BW-1:0] cfg_wr_scaler,
    input  logic [PRECISION-1:0] cfg_wr_frac,
    input  logic                 cfg_commit,
    output logic                 cfg_wr_err,
    output logic                 cfg_busy,
    output logic                 commit_done,
    input  logic                 in_tvalid,
    input  logic                 in_tlast,
    input  logic [USR_ID_BW-1:0] in_tuser,
    output logic                 scaler_gain_sign,
    output logic [SCALER_BW-1:0] scaler_gain,
    output logic [PRECISION-1:0] fraction_gain
);

    localparam int NUSR = 1 << USR_ID_BW;
    localparam int CW   = $clog2(IDLE_TO + 1);

`ifdef JB_GAIN_SCHED_RAMP_EN
    typedef enum logic [1:0] {IDLE, ARMED, SWAP, RAMP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ARMED, SWAP} state_t;
`endif

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic done_q, done_d;

    logic                 sh_sign_q [NUSR];
    logic                 sh_sign_d [NUSR];
    logic [SCALER_BW-1:0] sh_scl_q  [NUSR];
    logic [SCALER_BW-1:0] sh_scl_d  [NUSR];
    logic [PRECISION-1:0] sh_frac_q [NUSR];
    logic [PRECISION-1:0] sh_frac_d [NUSR];
    logic                 ac_sign_q [NUSR];
    logic                 ac_sign_d [NUSR];
    logic [SCALER_BW-1:0] ac_scl_q  [NUSR];
    logic [SCALER_BW-1:0] ac_scl_d  [NUSR];
    logic [PRECISION-1:0] ac_frac_q [NUSR];
    logic [PRECISION-1:0] ac_frac_d [NUSR];

    logic idle_hit;
    logic boundary;
    logic all_eq;

    // Idle timeout counts only idle enabled cycles; a valid beat restarts it.
    assign idle_hit = !in_tvalid && (int'(cnt_q) + 1 >= IDLE_TO);
    assign boundary = (in_tvalid && in_tlast) || idle_hit;

`ifdef JB_GAIN_SCHED_RAMP_EN
    logic [PRECISION-1:0] tg_q [NUSR];
    logic [PRECISION-1:0] tg_d [NUSR];

    function automatic logic [PRECISION-1:0] ramp_f(
        input logic [PRECISION-1:0] a,
        input logic [PRECISION-1:0] t
    );
        logic [PRECISION:0] s;
        s = {1'b0, a} + {1'b0, RAMP_STEP};
        if (a < t)
            ramp_f = (s >= {1'b0, t}) ? t : s[PRECISION-1:0];
        else
            ramp_f = (a - t <= RAMP_STEP) ? t : a - RAMP_STEP;
    endfunction

    always_comb begin
        all_eq = 1'b1;
        for (int u = 0; u < NUSR; u++)
            if (ac_frac_q[u] != tg_q[u]) all_eq = 1'b0;
    end
`else
    assign all_eq = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clk_en) begin
            unique case (state_q)
                IDLE:  if (cfg_commit) state_d = ARMED;
                ARMED: if (boundary)   state_d = SWAP;
`ifdef JB_GAIN_SCHED_RAMP_EN
                SWAP:  state_d = RAMP;
                RAMP:  if (all_eq)     state_d = IDLE;
`else
                SWAP:  state_d = IDLE;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_busy         = (state_q != IDLE);
        cfg_wr_err       = err_q;
        commit_done      = done_q;
        scaler_gain_sign = ac_sign_q[in_tuser];
        scaler_gain      = ac_scl_q[in_tuser];
        fraction_gain    = ac_frac_q[in_tuser];
    end

    always_comb begin
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_d    = done_q;
        sh_sign_d = sh_sign_q;
        sh_scl_d  = sh_scl_q;
        sh_frac_d = sh_frac_q;
        ac_sign_d = ac_sign_q;
        ac_scl_d  = ac_scl_q;
        ac_frac_d = ac_frac_q;
`ifdef JB_GAIN_SCHED_RAMP_EN
        tg_d      = tg_q;
`endif
        if (clk_en) begin
            err_d  = (cfg_wr_en || cfg_commit) && (state_q != IDLE);
            done_d = (state_q != IDLE) && (state_q != ARMED) && (state_d == IDLE);
            if (in_tvalid || (state_q == IDLE && cfg_commit))
                cnt_d = '0;
            else if (!idle_hit)
                cnt_d = cnt_q + CW'(1);
            if (state_q == IDLE && cfg_wr_en) begin
                sh_sign_d[cfg_wr_usr] = cfg_wr_sign;
                sh_scl_d[cfg_wr_usr]  = cfg_wr_scaler;
                sh_frac_d[cfg_wr_usr] = cfg_wr_frac;
            end
            // Copy on the boundary edge so the very next beat sees new gains.
            if (state_q == ARMED && boundary) begin
                for (int u = 0; u < NUSR; u++) begin
                    ac_sign_d[u] = sh_sign_q[u];
                    ac_scl_d[u]  = sh_scl_q[u];
`ifdef JB_GAIN_SCHED_RAMP_EN
                    tg_d[u]      = sh_frac_q[u];
`else
                    ac_frac_d[u] = sh_frac_q[u];
`endif
                end
            end
`ifdef JB_GAIN_SCHED_RAMP_EN
            if (state_q == RAMP && in_tvalid)
                ac_frac_d[in_tuser] = ramp_f(ac_frac_q[in_tuser], tg_q[in_tuser]);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            for (int u = 0; u < NUSR; u++) begin
                sh_sign_q[u] <= 1'b0;
                sh_scl_q[u]  <= '0;
                sh_frac_q[u] <= RESET_FRAC;
                ac_sign_q[u] <= 1'b0;
                ac_scl_q[u]  <= '0;
                ac_frac_q[u] <= RESET_FRAC;
`ifdef JB_GAIN_SCHED_RAMP_EN
                tg_q[u]      <= RESET_FRAC;
`endif
            end
        end else begin
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
            sh_sign_q <= sh_sign_d;
            sh_scl_q  <= sh_scl_d;
            sh_frac_q <= sh_frac_d;
            ac_sign_q <= ac_sign_d;
            ac_scl_q  <= ac_scl_d;
            ac_frac_q <= ac_frac_d;
`ifdef JB_GAIN_SCHED_RAMP_EN
            tg_q      <= tg_d;
`endif
        end
    end

endmodule

// File: tb/tb_jb_iq_gain_sched.sv
// Directed self-checking bench for jb_iq_gain_sched (default build, or ramp
// sequence when JB_GAIN_SCHED_RAMP_EN is defined).
module tb_jb_iq_gain_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        cfg_wr_en;
    logic [1:0]  cfg_wr_usr;
    logic        cfg_wr_sign;
    logic [3:0]  cfg_wr_scaler;
    logic [15:0] cfg_wr_frac;
    logic        cfg_commit;
    logic        cfg_wr_err;
    logic        cfg_busy;
    logic        commit_done;
    logic        in_tvalid;
    logic        in_tlast;
    logic [1:0]  in_tuser;
    logic        scaler_gain_sign;
    logic [3:0]  scaler_gain;
    logic [15:0] fraction_gain;

    int checks = 0;
    int failures = 0;

    jb_iq_gain_sched dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_usr(cfg_wr_usr),
        .cfg_wr_sign(cfg_wr_sign), .cfg_wr_scaler(cfg_wr_scaler),
        .cfg_wr_frac(cfg_wr_frac), .cfg_commit(cfg_commit),
        .cfg_wr_err(cfg_wr_err), .cfg_busy(cfg_busy),
        .commit_done(commit_done), .in_tvalid(in_tvalid),
        .in_tlast(in_tlast), .in_tuser(in_tuser),
        .scaler_gain_sign(scaler_gain_sign), .scaler_gain(scaler_gain),
        .fraction_gain(fraction_gain)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  usr;
        logic        sign;
        logic [3:0]  scl;
        logic [15:0] frac;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    task automatic expg(input string n, input logic s, input logic [3:0] sc,
                        input logic [15:0] f);
        chk({n, ".sign"}, 32'(scaler_gain_sign), 32'(s));
        chk({n, ".scl"}, 32'(scaler_gain), 32'(sc));
        chk({n, ".frac"}, 32'(fraction_gain), 32'(f));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] u, input logic s, input logic [3:0] sc,
                      input logic [15:0] f);
        cfg_wr_en = 1'b1;
        cfg_wr_usr = u;
        cfg_wr_sign = s;
        cfg_wr_scaler = sc;
        cfg_wr_frac = f;
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        clk_en = 1'b1;
        cfg_wr_en = 1'b0;
        cfg_wr_usr = '0;
        cfg_wr_sign = 1'b0;
        cfg_wr_scaler = '0;
        cfg_wr_frac = '0;
        cfg_commit = 1'b0;
        in_tvalid = 1'b0;
        in_tlast = 1'b0;
        in_tuser = '0;
        tbl[0] = '{2'd0, 1'b1, 4'd3, 16'h1234};
        tbl[1] = '{2'd1, 1'b1, 4'd15, 16'hFFFF};
        tbl[2] = '{2'd2, 1'b0, 4'd9, 16'h0001};
        tbl[3] = '{2'd3, 1'b1, 4'd0, 16'h8000};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int u = 0; u < 4; u++) begin
            in_tuser = 2'(u);
            #1;
            expg("reset", 1'b0, 4'd0, 16'h7FFF);
        end
        chk("reset.busy", 32'(cfg_busy), 0);
        chk("reset.err", 32'(cfg_wr_err), 0);
        chk("reset.done", 32'(commit_done), 0);

`ifdef JB_GAIN_SCHED_RAMP_EN
        begin
            logic [15:0] rexp [5];
            rexp = '{16'h7FFF, 16'h7EFF, 16'h7DFF, 16'h7CFF, 16'h7C00};
            tick();
            wr(2'd0, 1'b0, 4'd0, 16'h7C00);
            cfg_commit = 1'b1;
            in_tuser = 2'd0;
            tick();
            cfg_wr_en = 1'b0;
            cfg_commit = 1'b0;
            in_tvalid = 1'b1;
            in_tlast = 1'b1;
            tick();
            in_tlast = 1'b0;
            #1;
            chk("ramp.swap_frac", 32'(fraction_gain), 32'h7FFF);
            tick();
            for (int k = 0; k < 4; k++) begin
                #1;
                chk("ramp.step", 32'(fraction_gain), 32'(rexp[k]));
                chk("ramp.nodone", 32'(commit_done), 0);
                tick();
            end
            in_tvalid = 1'b0;
            #1;
            chk("ramp.final", 32'(fraction_gain), 32'(rexp[4]));
            chk("ramp.busy", 32'(cfg_busy), 1);
            tick();
            chk("ramp.done", 32'(commit_done), 1);
            chk("ramp.idle", 32'(cfg_busy), 0);
        end
`else
        // Mid-frame commit: swap takes effect on the beat after tlast.
        tick();
        wr(2'd1, 1'b0, 4'd2, 16'h4000);
        in_tvalid = 1'b1;
        in_tuser = 2'd1;
        #1;
        expg("mf.pre", 1'b0, 4'd0, 16'h7FFF);
        tick();
        cfg_wr_en = 1'b0;
        cfg_commit = 1'b1;
        #1;
        chk("mf.busy0", 32'(cfg_busy), 0);
        expg("mf.commit", 1'b0, 4'd0, 16'h7FFF);
        tick();
        cfg_commit = 1'b0;
        #1;
        chk("mf.busy1", 32'(cfg_busy), 1);
        expg("mf.armed", 1'b0, 4'd0, 16'h7FFF);
        tick();
        in_tlast = 1'b1;
        #1;
        expg("mf.tlast", 1'b0, 4'd0, 16'h7FFF);
        tick();
        in_tlast = 1'b0;
        #1;
        expg("mf.new", 1'b0, 4'd2, 16'h4000);
        chk("mf.done_early", 32'(commit_done), 0);
        tick();
        chk("mf.done", 32'(commit_done), 1);
        chk("mf.busy_end", 32'(cfg_busy), 0);
        tick();
        in_tvalid = 1'b0;
        chk("mf.done_once", 32'(commit_done), 0);

        // Idle-timeout commit; a valid beat at k=40 restarts the count.
        for (int i = 0; i < 4; i++) begin
            wr(tbl[i].usr, tbl[i].sign, tbl[i].scl, tbl[i].frac);
            cfg_commit = (i == 3);
            tick();
        end
        cfg_wr_en = 1'b0;
        cfg_commit = 1'b0;
        for (int k = 1; k <= 106; k++) begin
            in_tvalid = (k == 40);
            in_tuser = 2'd1;
            #1;
            if (k == 64 || k == 104) begin
                expg("idle.old", 1'b0, 4'd2, 16'h4000);
                chk("idle.busy", 32'(cfg_busy), 1);
            end
            if (k == 105) expg("idle.new", 1'b1, 4'd15, 16'hFFFF);
            if (k == 106) chk("idle.done", 32'(commit_done), 1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            in_tuser = tbl[i].usr;
            #1;
            expg("tbl", tbl[i].sign, tbl[i].scl, tbl[i].frac);
        end

        // Writes/commits in ARMED are rejected and leave the shadow intact.
        wr(2'd0, 1'b0, 4'd5, 16'h1111);
        tick();
        cfg_wr_en = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        in_tuser = 2'd0;
        for (int k = 1; k <= 66; k++) begin
            if (k == 1) wr(2'd0, 1'b1, 4'd7, 16'h2222);
            else cfg_wr_en = 1'b0;
            cfg_commit = (k == 2);
            #1;
            if (k == 1) chk("rej.err0", 32'(cfg_wr_err), 0);
            if (k == 2 || k == 3) chk("rej.err1", 32'(cfg_wr_err), 1);
            if (k == 4) chk("rej.err_clr", 32'(cfg_wr_err), 0);
            if (k == 64) expg("rej.old", 1'b1, 4'd3, 16'h1234);
            if (k == 65) expg("rej.new", 1'b0, 4'd5, 16'h1111);
            tick();
        end

        // clk_en at 50%: idle count stretches, disabled tlast is ignored.
        wr(2'd3, 1'b1, 4'd1, 16'hABCD);
        tick();
        cfg_wr_en = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int k = 1; k <= 133; k++) begin
            clk_en = (k % 2 == 0);
            in_tvalid = (k == 11);
            in_tlast = (k == 11);
            in_tuser = 2'd3;
            #1;
            if (k == 12 || k == 128) expg("ce.old", 1'b1, 4'd0, 16'h8000);
            if (k == 129) expg("ce.new", 1'b1, 4'd1, 16'hABCD);
            if (k == 130) chk("ce.busy", 32'(cfg_busy), 1);
            if (k == 131) begin
                chk("ce.idle", 32'(cfg_busy), 0);
                chk("ce.done", 32'(commit_done), 1);
            end
            tick();
        end
        clk_en = 1'b1;
        in_tvalid = 1'b0;
        in_tlast = 1'b0;
        tick();

        // Reset while ARMED drops the commit.
        wr(2'd2, 1'b0, 4'd3, 16'h0F0F);
        tick();
        cfg_wr_en = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        repeat (5) tick();
        chk("rst.armed", 32'(cfg_busy), 1);
        rst = 1'b1;
        in_tuser = 2'd0;
        #1;
        expg("rst.gain", 1'b0, 4'd0, 16'h7FFF);
        chk("rst.busy", 32'(cfg_busy), 0);
        tick();
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (commit_done) dones++;
        end
        chk("rst.no_done", 32'(dones), 0);
        chk("rst.busy_after", 32'(cfg_busy), 0);
        in_tuser = 2'd2;
        #1;
        expg("rst.usr2", 1'b0, 4'd0, 16'h7FFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
